// File: rtl/reg_pipeline_if.sv
// reg_pipeline_if: streaming handshake bundle for reg_pipeline.
//   in_valid/in_data/in_ready    producer side (producer -> pipeline)
//   out_valid/out_data/out_ready consumer side (pipeline -> consumer)
//   occupancy                    count of valid stages (only with REG_PIPE_OCC_EN)
// Modports: master = producer/consumer environment, slave = the pipeline itself.
interface reg_pipeline_if #(
  parameter int unsigned WIDTH  = 15
`ifdef REG_PIPE_OCC_EN
  , parameter int unsigned STAGES = 2
`endif
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef REG_PIPE_OCC_EN
  logic [$clog2(STAGES + 1)-1:0] occupancy;
`endif

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
`ifdef REG_PIPE_OCC_EN
    , input occupancy
`endif
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
`ifdef REG_PIPE_OCC_EN
    , output occupancy
`endif
  );

endinterface

// File: rtl/reg_pipeline.sv
// reg_pipeline: elastic valid/ready register pipeline of STAGES WIDTH-bit stages.
// Bubbles collapse in a single cycle, order is strict FIFO, capacity = STAGES,
// minimum latency = STAGES-1 edges after acceptance.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (clears valids and data)
//   clear  synchronous flush of all valid bits; data registers hold
//   bus    reg_pipeline_if.slave (in_valid/in_data/in_ready, out_valid/out_data/out_ready,
//          occupancy when REG_PIPE_OCC_EN is defined)
// Build option: define REG_PIPE_OCC_EN to add the registered occupancy counter.
module reg_pipeline #(
  parameter int unsigned WIDTH  = 15,
  parameter int unsigned STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  reg_pipeline_if.slave bus
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] adv_c;
  logic [STAGES-1:0] load_c;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic              in_ready_c;
  logic              in_xfer_c;

  // Advance chain runs from the output stage back to the input, so a stage may
  // move into a slot that is being vacated in the same cycle.
  always_comb begin
    adv_c           = '0;
    adv_c[STAGES-1] = v_q[STAGES-1] && bus.out_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      adv_c[i] = v_q[i] && (!v_q[i+1] || adv_c[i+1]);
    end

    in_ready_c = !clear && (!v_q[0] || adv_c[0]);
    in_xfer_c  = bus.in_valid && in_ready_c;

    // clear suppresses every load so data registers keep their contents
    load_c    = '0;
    load_c[0] = in_xfer_c;
    for (int i = 1; i < int'(STAGES); i++) begin
      load_c[i] = !clear && adv_c[i-1];
    end

    v_d = '0;
    if (!clear) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        v_d[i] = load_c[i] || (v_q[i] && !adv_c[i]);
      end
    end
  end

  // Stage registers: valids every cycle, data only on load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      if (load_c[0]) begin
        d_q[0] <= bus.in_data;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (load_c[i]) begin
          d_q[i] <= d_q[i-1];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.out_data  = d_q[STAGES-1];

`ifdef REG_PIPE_OCC_EN
  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             out_xfer_c;

  // Output transfer is void under clear, matching the flushed valids
  always_comb begin
    out_xfer_c = !clear && adv_c[STAGES-1];
    occ_d      = occ_q;
    if (clear) begin
      occ_d = '0;
    end else if (in_xfer_c && !out_xfer_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!in_xfer_c && out_xfer_c) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Occupancy counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.occupancy = occ_q;
`else
  // occupancy tracking not built
`endif

endmodule

// File: tb/tb_reg_pipeline.sv
module tb_reg_pipeline;

  localparam int unsigned W = 15;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  always #5 clk = ~clk;

`ifdef REG_PIPE_OCC_EN
  reg_pipeline_if #(.WIDTH(W), .STAGES(2)) bus2 ();
  reg_pipeline_if #(.WIDTH(W), .STAGES(4)) bus4 ();
`else
  reg_pipeline_if #(.WIDTH(W)) bus2 ();
  reg_pipeline_if #(.WIDTH(W)) bus4 ();
`endif

  assign bus2.in_valid  = in_valid;
  assign bus2.in_data   = in_data;
  assign bus2.out_ready = out_ready;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_data   = in_data;
  assign bus4.out_ready = out_ready;

  reg_pipeline #(.WIDTH(W), .STAGES(2)) u_dut2 (.clk(clk), .reset(reset), .clear(clear), .bus(bus2));
  reg_pipeline #(.WIDTH(W), .STAGES(4)) u_dut4 (.clk(clk), .reset(reset), .clear(clear), .bus(bus4));

  // Selected DUT view
  int           sel = 0;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  assign a_valid = (sel == 1) ? bus4.out_valid : bus2.out_valid;
  assign a_ready = (sel == 1) ? bus4.in_ready  : bus2.in_ready;
  assign a_data  = (sel == 1) ? bus4.out_data  : bus2.out_data;
`ifdef REG_PIPE_OCC_EN
  logic [2:0] a_occ;
  assign a_occ = (sel == 1) ? 3'(bus4.occupancy) : 3'(bus2.occupancy);
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO of words with the edge each was accepted. A head word
  // is visible once it has aged STAGES-1 edges and its predecessor has left.
  int           S = 2;
  logic [W-1:0] mq[$];
  int           aq[$];
  int           cyc = 0;
  int           last_dep = 0;

  function automatic bit m_valid();
    return (mq.size() > 0) && (cyc >= aq[0] + S - 1) && (cyc >= last_dep);
  endfunction

  function automatic bit m_ready();
    return !clear && ((mq.size() < S) || out_ready);
  endfunction

  task automatic m_flush();
    mq.delete();
    aq.delete();
    last_dep = 0;
  endtask

  // Advance model by the coming edge using the inputs now applied, then sample point
  task automatic tick();
    bit ov, rdy;
    ov  = m_valid();
    rdy = m_ready();
    if (clear) begin
      mq.delete();
      aq.delete();
    end else begin
      if (ov && out_ready) begin
        void'(mq.pop_front());
        void'(aq.pop_front());
        last_dep = cyc + 1;
      end
      if (in_valid && rdy) begin
        mq.push_back(in_data);
        aq.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 15'h2AAA; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_flush();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      checks++;
      if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid sel=%0d: got %b want 0", s, a_valid); end
      checks++;
      if (a_data !== '0) begin errors++; $display("FAIL reset_out_data sel=%0d: got %h want 0", s, a_data); end
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready sel=%0d: got %b want 1", s, a_ready); end
`ifdef REG_PIPE_OCC_EN
      checks++;
      if (a_occ !== 3'd0) begin errors++; $display("FAIL reset_occ sel=%0d: got %0d want 0", s, a_occ); end
`endif
    end
    sel = 0; S = 2; in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 15'h1234;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b want 1", a_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle0_valid: got %b want 0", a_valid); end
    tick();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 15'h1234)
      begin errors++; $display("FAIL lat_cycle1: got v=%b d=%h want v=1 d=1234", a_valid, a_data); end
    tick();
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle2_valid: got %b want 0", a_valid); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w[3];
    int idx, got;
    w[0] = 15'h0001; w[1] = 15'h0002; w[2] = 15'h0003;
    idx = 0; got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = w[idx];
      #1;
      checks++;
      if (a_ready !== m_ready()) begin errors++; $display("FAIL bp_fill_ready c=%0d: got %b want %b", c, a_ready, m_ready()); end
      if (m_ready()) idx++;
      tick();
    end
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", a_ready); end
    checks++;
    if (a_valid !== 1'b1 || a_data !== 15'h0001)
      begin errors++; $display("FAIL bp_full_head: got v=%b d=%h want v=1 d=0001", a_valid, a_data); end
`ifdef REG_PIPE_OCC_EN
    checks++;
    if (a_occ !== 3'd2) begin errors++; $display("FAIL bp_full_occ: got %0d want 2", a_occ); end
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      in_valid = (idx < 3); in_data = w[idx < 3 ? idx : 2];
      #1;
      checks++;
      if (a_ready !== m_ready()) begin errors++; $display("FAIL bp_drain_ready c=%0d: got %b want %b", c, a_ready, m_ready()); end
      if (a_valid) begin
        checks++;
        if (a_data !== w[got]) begin errors++; $display("FAIL bp_order n=%0d: got %h want %h", got, a_data, w[got]); end
        got++;
      end
      if (in_valid && m_ready()) idx++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 3) begin errors++; $display("FAIL bp_delivered: got %0d words want 3", got); end
  endtask

  task automatic test_stream(input int s_sel, input int s_stages);
    logic [W-1:0] sb[$];
    int rx;
    sel = s_sel; S = s_stages; rx = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 2) tick();
    for (int c = 0; c < 100 + S + 2; c++) begin
      in_valid = (c < 100);
      in_data  = W'($urandom);
      #1;
      if (in_valid) begin
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL stream_ready S=%0d c=%0d: got %b want 1", S, c, a_ready); end
      end
      checks++;
      if (a_valid !== m_valid()) begin errors++; $display("FAIL stream_valid S=%0d c=%0d: got %b want %b", S, c, a_valid, m_valid()); end
      if (a_valid) begin
        checks++;
        if (sb.size() == 0 || a_data !== sb[0])
          begin errors++; $display("FAIL stream_order S=%0d n=%0d: got %h want %h", S, rx, a_data, (sb.size() > 0) ? sb[0] : '0); end
        if (sb.size() > 0) void'(sb.pop_front());
        rx++;
      end
      if (in_valid && a_ready) sb.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (rx !== 100) begin errors++; $display("FAIL stream_count S=%0d: got %0d want 100", S, rx); end
  endtask

  task automatic test_clear();
    sel = 0; S = 2;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_data = W'(15'h0A00 + c);
      tick();
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 15'h5555;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %b want 0", a_ready); end
    checks++;
    if (a_valid !== 1'b1 || a_data !== 15'h0A00)
      begin errors++; $display("FAIL clear_pre_state: got v=%b d=%h want v=1 d=0a00", a_valid, a_data); end
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL clear_post_valid: got %b want 0", a_valid); end
`ifdef REG_PIPE_OCC_EN
    checks++;
    if (a_occ !== 3'd0) begin errors++; $display("FAIL clear_post_occ: got %0d want 0", a_occ); end
`endif
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (a_valid !== 1'b0) begin errors++; $display("FAIL clear_leak c=%0d: got v=%b d=%h want v=0", c, a_valid, a_data); end
    end
  endtask

  task automatic test_random(input int s_sel, input int s_stages, input int n);
    sel = s_sel; S = s_stages;
    for (int c = 0; c < n; c++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(4, 0) > 1);
      clear     = ($urandom_range(19, 0) == 0);
      in_data   = W'($urandom);
      #1;
      checks++;
      if (a_ready !== m_ready()) begin errors++; $display("FAIL rand_ready S=%0d c=%0d: got %b want %b", S, c, a_ready, m_ready()); end
      checks++;
      if (a_valid !== m_valid()) begin errors++; $display("FAIL rand_valid S=%0d c=%0d: got %b want %b", S, c, a_valid, m_valid()); end
      if (m_valid()) begin
        checks++;
        if (a_data !== mq[0]) begin errors++; $display("FAIL rand_data S=%0d c=%0d: got %h want %h", S, c, a_data, mq[0]); end
      end
`ifdef REG_PIPE_OCC_EN
      checks++;
      if (a_occ !== 3'(mq.size())) begin errors++; $display("FAIL rand_occ S=%0d c=%0d: got %0d want %0d", S, c, a_occ, mq.size()); end
`endif
      tick();
    end
    clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1; S = 4;
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_flush();
    tick();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (a_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b want 1", a_valid); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (a_valid !== 1'b0 || a_data !== '0)
      begin errors++; $display("FAIL rmid_async: got v=%b d=%h want v=0 d=0", a_valid, a_data); end
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", a_ready); end
`ifdef REG_PIPE_OCC_EN
    checks++;
    if (a_occ !== 3'd0) begin errors++; $display("FAIL rmid_occ: got %0d want 0", a_occ); end
`endif
    #2 reset = 1'b0;
    m_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 15'h7FFF;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (a_valid !== (k == 3))
        begin errors++; $display("FAIL rmid_latency k=%0d: got v=%b want %b", k, a_valid, (k == 3)); end
      if (k == 3) begin
        checks++;
        if (a_data !== 15'h7FFF) begin errors++; $display("FAIL rmid_data: got %h want 7fff", a_data); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_stream(0, 2);
    test_clear();
    test_random(0, 2, 400);
    test_reset_mid();
    test_stream(1, 4);
    test_random(1, 4, 400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
